// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready handshake on both sides.
//
// Non-multiply operations finish on the edge that accepts them. MUL runs a
// shift-and-add loop that takes one multiplier bit per cycle.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   block can accept a request (high only in IDLE)
//   op         4-bit opcode
//   a, b       WIDTH-bit operands
//   out_valid  result and flags valid (high only in DONE)
//   out_ready  consumer takes the result
//   result     registered WIDTH-bit result
//   zero, neg, carry, ovf   registered flags
// ---------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_PASS = 4'd7;
   localparam logic [3:0] OP_SUB  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   // The counter runs 0..WIDTH: WIDTH iterations, then one edge to publish.
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   logic [1:0]         state;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mplier;
   logic [SHW:0]       cnt;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH:0]     wide;
   logic [SHW-1:0]     sh;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign sh        = b[SHW-1:0];

   // Single-cycle datapath, evaluated from the live inputs so that the
   // result can be registered on the accept edge itself. Shifts go through
   // a WIDTH+1 bit vector so the extra bit holds the last bit shifted out
   // (and stays 0 for a zero shift amount).
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      wide    = '0;
      case (op)
         OP_OR:   alu_res = a | b;
         OP_AND:  alu_res = a & b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOT:  alu_res = ~a;
         OP_PASS: alu_res = a;
         OP_ADD: begin
            wide    = {1'b0, a} + {1'b0, b};
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            wide    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SHL: begin
            wide    = {1'b0, a} << sh;
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         OP_SHR: begin
            wide    = {a, 1'b0} >> sh;
            alu_res = wide[WIDTH:1];
            alu_c   = wide[0];
         end
         default: ;
      endcase
   end

   // Control FSM plus the multiply loop. Result and flags only change on
   // the accept edge (non-MUL) or the final MUL edge, so they hold steady
   // throughout DONE regardless of what the inputs do.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         mcand  <= '0;
         prod   <= '0;
         mplier <= '0;
         cnt    <= '0;
         result <= '0;
         zero   <= 1'b1;
         neg    <= 1'b0;
         carry  <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (op == OP_MUL) begin
                     mcand  <= {{WIDTH{1'b0}}, a};
                     mplier <= b;
                     prod   <= '0;
                     cnt    <= '0;
                     state  <= S_MUL;
                  end else begin
                     result <= alu_res;
                     zero   <= (alu_res == '0);
                     neg    <= alu_res[WIDTH-1];
                     carry  <= alu_c;
                     ovf    <= alu_v;
                     state  <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               if (cnt == CNT_LAST) begin
                  result <= prod[WIDTH-1:0];
                  zero   <= (prod[WIDTH-1:0] == '0);
                  neg    <= prod[WIDTH-1];
                  carry  <= |prod[2*WIDTH-1:WIDTH];
                  ovf    <= 1'b0;
                  state  <= S_DONE;
               end else begin
                  if (mplier[0]) begin
                     prod <= prod + mcand;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CNT_ONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- directed self-checking bench for seq_alu (WIDTH = 8).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// at the same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_seq_alu;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero;
   logic       neg;
   logic       carry;
   logic       ovf;

   int tests_run;
   int tests_failed;
   int edges;

   seq_alu #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Checks result and all four flags at once.
   task automatic checkAll(input string tag, input logic [7:0] r, input logic z,
                           input logic n, input logic c, input logic v);
      checkOutput({tag, ".result"}, 32'(result), 32'(r));
      checkOutput({tag, ".zero"},   32'(zero),   32'(z));
      checkOutput({tag, ".neg"},    32'(neg),    32'(n));
      checkOutput({tag, ".carry"},  32'(carry),  32'(c));
      checkOutput({tag, ".ovf"},    32'(ovf),    32'(v));
   endtask

   // Offers one request on the next edge, then counts further edges until
   // out_valid shows up (bounded). Called from a point just after an edge.
   task automatic applyStimulus(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'hA5;
      b        = 8'h5A;
      op       = 4'd3;
      edges    = 0;
      while (!out_valid && edges < 30) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   // Takes the result and checks the block went back to IDLE.
   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, ".out_valid_after_take"}, 32'(out_valid), 32'd0);
      checkOutput({tag, ".in_ready_after_take"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      op           = 4'd0;
      a            = 8'd0;
      b            = 8'd0;
      edges        = 0;

      // Reset state
      #12;
      checkAll("reset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
      checkOutput("reset.out_valid", 32'(out_valid), 32'd0);

      // Release between edges; first edge afterwards must accept.
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      applyStimulus(4'd5, 8'd250, 8'd7);
      checkOutput("add1.latency", 32'(edges), 32'd0);
      checkOutput("add1.in_ready_in_done", 32'(in_ready), 32'd0);
      checkAll("add1", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      consume("add1");

      applyStimulus(4'd5, 8'd127, 8'd1);
      checkAll("add_ovf", 8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
      consume("add_ovf");

      applyStimulus(4'd8, 8'd5, 8'd5);
      checkAll("sub_eq", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      consume("sub_eq");

      applyStimulus(4'd8, 8'd3, 8'd5);
      checkAll("sub_borrow", 8'd254, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("sub_borrow");

      applyStimulus(4'd8, 8'h80, 8'd1);
      checkAll("sub_ovf", 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
      consume("sub_ovf");

      applyStimulus(4'd10, 8'd13, 8'd11);
      checkOutput("mul1.latency", 32'(edges), 32'd9);
      checkAll("mul1", 8'd143, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("mul1");

      applyStimulus(4'd10, 8'd20, 8'd20);
      checkOutput("mul2.latency", 32'(edges), 32'd9);
      checkAll("mul2", 8'd144, 1'b0, 1'b1, 1'b1, 1'b0);
      consume("mul2");

      applyStimulus(4'd10, 8'd255, 8'd255);
      checkAll("mul_max", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      consume("mul_max");

      applyStimulus(4'd6, 8'h81, 8'd1);
      checkAll("shl1", 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
      consume("shl1");

      applyStimulus(4'd6, 8'h81, 8'd0);
      checkAll("shl0", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("shl0");

      applyStimulus(4'd6, 8'h0B, 8'd5);
      checkAll("shl5", 8'h60, 1'b0, 1'b0, 1'b1, 1'b0);
      consume("shl5");

      applyStimulus(4'd9, 8'h81, 8'h09);
      checkAll("shr1", 8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
      consume("shr1");

      applyStimulus(4'd9, 8'hB0, 8'd3);
      checkAll("shr3", 8'h16, 1'b0, 1'b0, 1'b0, 1'b0);
      consume("shr3");

      applyStimulus(4'd15, 8'h12, 8'h34);
      checkOutput("illegal.latency", 32'(edges), 32'd0);
      checkAll("illegal", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      consume("illegal");

      applyStimulus(4'd1, 8'hF0, 8'h0C);
      checkAll("or", 8'hFC, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("or");

      applyStimulus(4'd2, 8'hF0, 8'h3C);
      checkAll("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      consume("and");

      applyStimulus(4'd3, 8'hFF, 8'h0F);
      checkAll("xor", 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("xor");

      applyStimulus(4'd4, 8'hFF, 8'h00);
      checkAll("not", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      consume("not");

      applyStimulus(4'd7, 8'h5A, 8'hFF);
      checkAll("pass", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      consume("pass");

      // Hold DONE for 5 cycles while new requests are offered.
      applyStimulus(4'd5, 8'd1, 8'd2);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op       = (i % 2 == 0) ? 4'd4 : 4'd10;
         a        = 8'(i * 37 + 9);
         b        = 8'(i * 11 + 200);
         @(posedge clk);
         #1;
         checkAll("stall", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("stall.in_ready",  32'(in_ready),  32'd0);
         checkOutput("stall.out_valid", 32'(out_valid), 32'd1);
      end
      // Request still offered on the edge that takes the result: not accepted.
      op        = 4'd5;
      a         = 8'd100;
      b         = 8'd100;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("stall_take.out_valid", 32'(out_valid), 32'd0);
      checkOutput("stall_take.in_ready",  32'(in_ready),  32'd1);
      checkOutput("stall_take.result",    32'(result),    32'd3);

      // Reset in the middle of a multiply (after 4 iterations).
      op       = 4'd10;
      a        = 8'd13;
      b        = 8'd11;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkAll("midreset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("midreset.in_ready",  32'(in_ready),  32'd1);
      checkOutput("midreset.out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("midreset.no_result", 32'(out_valid), 32'd0);
      applyStimulus(4'd5, 8'd2, 8'd3);
      checkOutput("after_reset.latency", 32'(edges), 32'd0);
      checkAll("after_reset", 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      consume("after_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
